uart_tx_multi: RTL
==================

UART_TX_MULTI -- requirements
Module: uart_tx_multi

Interface
REQ-001 SHALL have parameter N_CH, default 2, number of input channels (1..8).
REQ-002 SHALL have parameter DATA_W, default 8, data bits per frame (5..9).
REQ-003 SHALL have parameter CLK_DIV, default 5208, int_clk cycles per serial bit (>=2).
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits per frame (1 or 2).
REQ-005 SHALL have parameter PARITY_ODD, default 0, 1=odd parity, 0=even parity (used only with UART_TX_PARITY_EN).
REQ-006 SHALL have port int_clk  input  1  sole clock; all logic on rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port in_valid  input  N_CH  per-channel request.
REQ-009 SHALL have port in_data  input  N_CH*DATA_W  channel c at bits [c*DATA_W +: DATA_W].
REQ-010 SHALL have port in_ready  output  N_CH  one-hot accept pulse.
REQ-011 SHALL have port dout  output  1  serial line, idle high.
REQ-012 SHALL have port busy  output  1  high while a frame is in progress.
REQ-013 SHALL have port tx_ch  output  max(1,$clog2(N_CH))  channel of frame in progress.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse in last cycle of final stop bit.

Function
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-016 In IDLE with any in_valid high, SHALL assert in_ready for exactly one granted channel for one cycle, capture its data and tx_ch, and enter START next cycle.
REQ-017 Grant SHALL be round-robin: search begins at (last granted + 1) mod N_CH; channel 0 searched first after reset.
REQ-018 in_ready SHALL never assert outside IDLE; requests held high during a frame SHALL wait.
REQ-019 Each of START, each DATA bit, PARITY and each stop bit SHALL last exactly CLK_DIV cycles.
REQ-020 dout SHALL be 0 in START, data LSB first in DATA, parity bit in PARITY, 1 in STOP and IDLE.
REQ-021 DATA SHALL use a bit counter 0..DATA_W-1; PARITY follows if compiled in, else STOP.
REQ-022 STOP SHALL count STOP_BITS bit periods, pulse frame_done in final cycle, then return to IDLE.
REQ-023 Frame length SHALL be (1+DATA_W+P+STOP_BITS)*CLK_DIV cycles, P=1 with parity else 0; minimum one IDLE cycle between frames.
REQ-024 busy SHALL be high from the cycle after acceptance through the frame_done cycle.
REQ-025 Captured data SHALL be immune to in_data changes after acceptance.
REQ-026 Baud divider SHALL restart at 0 on acceptance so START is exactly CLK_DIV cycles.

Reset
REQ-027 rst SHALL immediately force IDLE, dout=1, busy=0, in_ready=0, frame_done=0, tx_ch=0, divider and bit counter=0, round-robin pointer to channel 0.
REQ-028 rst mid-frame SHALL abort the frame; no frame_done for it; next accept after rst deassertion starts a fresh frame.

Configuration
REQ-029 Macro UART_TX_PARITY_EN defined: PARITY state present; bit = XOR of data bits, inverted when PARITY_ODD=1.
REQ-030 UART_TX_PARITY_EN undefined: no PARITY state or logic; DATA goes directly to STOP.

Structure
REQ-031 Package uart_tx_pkg SHALL hold the state enum and STOP_BITS/DATA_W legal-range constants.
REQ-032 Sub-module uart_baud_gen SHALL provide the CLK_DIV bit-tick counter with synchronous restart input.

Verification (N_CH=2, DATA_W=8, CLK_DIV=4, STOP_BITS=1)
REQ-033 Ch0 sends 0x55, no parity -> in_ready[0] one cycle; dout 0,1,0,1,0,1,0,1,0,1 each 4 cycles; frame_done at cycle 40 after accept.
REQ-034 Both channels valid in IDLE, 0xA0 and 0x0F -> ch0 first, then ch1; tx_ch 0 then 1; one idle cycle between frames.
REQ-035 Ch1 held valid continuously, ch0 pulses once -> strict alternation after each ch0 request, no channel starved.
REQ-036 rst asserted at cycle 17 of a frame -> dout=1, busy=0 same cycle; no frame_done; next request yields a complete frame.
REQ-037 UART_TX_PARITY_EN, PARITY_ODD=0, data 0x07 -> parity bit 1; PARITY_ODD=1 -> 0; frame 44 cycles.
REQ-038 STOP_BITS=2, data 0xFF -> dout high 8 cycles after last data bit before frame_done.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared types and legal parameter ranges for the multi-channel UART transmitter.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_tx_pkg;

  localparam int unsigned DATA_W_MIN    = 5;
  localparam int unsigned DATA_W_MAX    = 9;
  localparam int unsigned STOP_BITS_MIN = 1;
  localparam int unsigned STOP_BITS_MAX = 2;
  localparam int unsigned N_CH_MAX      = 8;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;
`else
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;
`endif

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period tick generator: tick_o in the last cycle of each CLK_DIV period,
// pre_tick_o one cycle earlier; restart_i zeroes the count synchronously.
module uart_baud_gen #(
  parameter int unsigned CLK_DIV = 5208
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic restart_i,
  output logic tick_o,
  output logic pre_tick_o
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    tick_o     = (cnt_q == CNT_W'(CLK_DIV - 1));
    pre_tick_o = (cnt_q == CNT_W'(CLK_DIV - 2));
    if (restart_i || tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_multi.sv
// Round-robin multi-channel UART transmitter (8N1-style framing, configurable).
// Optional parity bit is compiled in with the UART_TX_PARITY_EN macro.
module uart_tx_multi
  import uart_tx_pkg::*;
#(
  parameter int unsigned N_CH       = 2,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned CLK_DIV    = 5208,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                                       int_clk,
  input  logic                                       rst,
  input  logic [N_CH-1:0]                            in_valid,
  input  logic [N_CH*DATA_W-1:0]                     in_data,
  output logic [N_CH-1:0]                            in_ready,
  output logic                                       dout,
  output logic                                       busy,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] tx_ch,
  output logic                                       frame_done
);

  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX ||
      STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX ||
      N_CH < 1 || N_CH > N_CH_MAX || CLK_DIV < 2 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_tx_multi: illegal parameter combination");
  end

  state_e              state_q;
  logic                dout_q;
  logic                busy_q;
  logic                frame_done_q;
  logic [CH_W-1:0]     tx_ch_q;
  logic [CH_W-1:0]     ptr_q;
  logic [3:0]          bit_cnt_q;
  logic [DATA_W-1:0]   shreg_q;
`ifdef UART_TX_PARITY_EN
  logic                parity_q;
`endif

  logic                grant_vld;
  logic [CH_W-1:0]     grant_idx;
  logic [CH_W-1:0]     ptr_d;
  logic [DATA_W-1:0]   grant_data;
  int unsigned         rr_idx;
  logic                accept;
  logic                tick;
  logic                pre_tick;
  logic                stop_last;

  // Round-robin search starting at ptr_q; first requesting channel wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    rr_idx    = 0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      rr_idx = (32'(ptr_q) + i) % N_CH;
      if (!grant_vld && in_valid[rr_idx]) begin
        grant_vld = 1'b1;
        grant_idx = CH_W'(rr_idx);
      end
    end
  end

  always_comb begin
    accept     = (state_q == IDLE) && grant_vld;
    in_ready   = accept ? (N_CH'(1) << grant_idx) : '0;
    grant_data = in_data[grant_idx*DATA_W +: DATA_W];
    ptr_d      = (grant_idx == CH_W'(N_CH - 1)) ? '0 : grant_idx + CH_W'(1);
    stop_last  = (bit_cnt_q == 4'(STOP_BITS - 1));
  end

  uart_baud_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_baud (
    .clk_i      (int_clk),
    .rst_i      (rst),
    .restart_i  (accept),
    .tick_o     (tick),
    .pre_tick_o (pre_tick)
  );

  // frame_done is registered, so it is armed one cycle early from pre_tick.
  always_ff @(posedge int_clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      dout_q       <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      tx_ch_q      <= '0;
      ptr_q        <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      frame_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_q   <= START;
            dout_q    <= 1'b0;
            busy_q    <= 1'b1;
            tx_ch_q   <= grant_idx;
            ptr_q     <= ptr_d;
            bit_cnt_q <= '0;
            shreg_q   <= grant_data;
`ifdef UART_TX_PARITY_EN
            parity_q  <= (^grant_data) ^ PARITY_ODD[0];
`endif
          end
        end
        START: begin
          if (tick) begin
            state_q <= DATA;
            dout_q  <= shreg_q[0];
            shreg_q <= {1'b1, shreg_q[DATA_W-1:1]};
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_cnt_q == 4'(DATA_W - 1)) begin
              bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
              state_q   <= PARITY;
              dout_q    <= parity_q;
`else
              state_q   <= STOP;
              dout_q    <= 1'b1;
`endif
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
              dout_q    <= shreg_q[0];
              shreg_q   <= {1'b1, shreg_q[DATA_W-1:1]};
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            state_q <= STOP;
            dout_q  <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (pre_tick && stop_last) begin
            frame_done_q <= 1'b1;
          end
          if (tick) begin
            if (stop_last) begin
              state_q   <= IDLE;
              busy_q    <= 1'b0;
              bit_cnt_q <= '0;
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          dout_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    dout       = dout_q;
    busy       = busy_q;
    tx_ch      = tx_ch_q;
    frame_done = frame_done_q;
  end

endmodule
